// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared state, width and response types for the APB requester.
package apb_pkg;

  localparam int APB_ADDR_W = 4;
  localparam int APB_DATA_W = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  error;
    logic                  timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_master_if.sv
// rtl/apb_master_if.sv - APB bus bundle between the requester and the slave subsystem.
interface apb_master_if
  import apb_pkg::*;
#(
  parameter int addr_width = APB_ADDR_W,
  parameter int data_width = APB_DATA_W
);

  logic                  PSELx;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [addr_width-1:0] PADDR;
  logic [data_width-1:0] PWDATA;
  logic [data_width-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_wait_timer.sv
// rtl/apb_wait_timer.sv - counts stalled ACCESS cycles; expired flags the last allowed stall.
module apb_wait_timer #(
  parameter int timeout_cycles = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (timeout_cycles == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst_n, clear, enable};
      assign expired       = 1'b0;
    end else begin : g_on
      localparam int CNT_W = $clog2(timeout_cycles + 1);
      localparam logic [CNT_W-1:0] LIMIT = CNT_W'(timeout_cycles);
      localparam logic [CNT_W-1:0] LAST  = CNT_W'(timeout_cycles - 1);

      logic [CNT_W-1:0] cnt_q, cnt_d;

      // Saturates at LIMIT so a held enable can never wrap back into range.
      always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
          cnt_d = '0;
        end else if (enable && (cnt_q != LIMIT)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign expired = enable && (cnt_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/apb_master.sv
// rtl/apb_master.sv - single-outstanding APB requester: valid/ready request in,
// SETUP/ACCESS on the bus, held response out with optional wait timeout.
module apb_master
  import apb_pkg::*;
#(
  parameter int addr_width     = APB_ADDR_W,
  parameter int data_width     = APB_DATA_W,
  parameter int timeout_cycles = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [addr_width-1:0] req_addr,
  input  logic [data_width-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [data_width-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  rsp_timeout,
  apb_master_if.master          bus
);

  apb_state_t            state_q, state_d;
  logic                  pwrite_q, pwrite_d;
  logic [addr_width-1:0] paddr_q, paddr_d;
  logic [data_width-1:0] pwdata_q, pwdata_d;
  apb_rsp_t              rsp_q, rsp_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  timer_expired;

  apb_wait_timer #(
    .timeout_cycles(timeout_cycles)
  ) u_wait_timer (
    .clk    (PCLK),
    .rst_n  (PRESETn),
    .clear  (state_q == SETUP),
    .enable ((state_q == ACCESS) && !bus.PREADY),
    .expired(timer_expired)
  );

  assign req_ready = (state_q == IDLE) && !rsp_valid_q;

  always_comb begin
    state_d     = state_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_d       = rsp_q;
    rsp_valid_d = rsp_valid_q;

    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          pwrite_d = req_write;
          paddr_d  = req_addr;
          pwdata_d = req_wdata;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        // PREADY is checked first so a completion on the final allowed cycle beats the timer.
        if (bus.PREADY) begin
          state_d       = IDLE;
          rsp_valid_d   = 1'b1;
          rsp_d.rdata   = pwrite_q ? '0 : APB_DATA_W'(bus.PRDATA);
          rsp_d.error   = bus.PSLVERR;
          rsp_d.timeout = 1'b0;
        end else if (timer_expired) begin
          state_d       = IDLE;
          rsp_valid_d   = 1'b1;
          rsp_d.rdata   = '0;
          rsp_d.error   = 1'b1;
          rsp_d.timeout = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign bus.PSELx   = (state_q != IDLE);
  assign bus.PENABLE = (state_q == ACCESS);
  assign bus.PWRITE  = pwrite_q;
  assign bus.PADDR   = paddr_q;
  assign bus.PWDATA  = pwdata_q;

  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_q.rdata[data_width-1:0];
  assign rsp_error   = rsp_q.error;
  assign rsp_timeout = rsp_q.timeout;

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
Single-outstanding APB requester that drives the slave-side bus (PSELx/PENABLE/PWRITE/PADDR/PWDATA) of the APB controller + RAM subsystem. A simple valid/ready request port on the user side is converted into a legal SETUP→ACCESS sequence. The block honours PREADY wait states, captures PRDATA/PSLVERR, and returns a held response with valid/ready handshake. A bounded wait timer aborts transactions that stall forever.

Parameters:
addr_width, 4, width of PADDR / req_addr
data_width, 128, width of PWDATA / PRDATA / req_wdata / rsp_rdata
timeout_cycles, 16, maximum ACCESS cycles with PREADY=0 before abort; 0 disables the timeout

Ports:
PCLK  in  1  bus clock, all logic on rising edge
PRESETn  in  1  asynchronous active-low reset
req_valid  in  1  user request present
req_ready  out  1  block accepts request this cycle
req_write  in  1  1=write, 0=read
req_addr  in  addr_width  transfer address
req_wdata  in  data_width  write data
rsp_valid  out  1  response available, held until rsp_ready
rsp_ready  in  1  user consumes response
rsp_rdata  out  data_width  read data (0 for writes and timeouts)
rsp_error  out  1  PSLVERR seen or timeout
rsp_timeout  out  1  transfer aborted by wait timer
PSELx  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  addr_width  APB address
PWDATA  out  data_width  APB write data
PRDATA  in  data_width  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB slave error

Behaviour:
- States: IDLE, SETUP, ACCESS. Reset → IDLE.
- Reset values: PSELx=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, rsp_timeout=0, wait counter=0.
- req_ready is combinational: state==IDLE && !rsp_valid. It is 1 out of reset.
- IDLE: on req_valid&&req_ready, register write/addr/wdata onto PWRITE/PADDR/PWDATA. Next state SETUP.
- SETUP (exactly 1 cycle): PSELx=1, PENABLE=0. PREADY/PSLVERR are ignored. Next state ACCESS.
- ACCESS: PSELx=1, PENABLE=1. PADDR/PWRITE/PWDATA are stable throughout.
  - PREADY=1: complete. Next cycle state=IDLE, PSELx=PENABLE=0, rsp_valid=1, rsp_error=PSLVERR, rsp_timeout=0. rsp_rdata=PRDATA for reads, 0 for writes.
  - PREADY=0: increment the wait counter.
  - Timeout: timeout_cycles!=0 and the counter reaches timeout_cycles. Next cycle state=IDLE, PSELx=PENABLE=0, rsp_valid=1, rsp_error=1, rsp_timeout=1, rsp_rdata=0.
  - The counter clears on every SETUP entry.
- PREADY and timeout reached in the same cycle: PREADY wins, giving a normal completion.
- Latency: accept at edge N, SETUP in cycle N+1, ACCESS in N+2. With zero wait states rsp_valid rises at N+3. Each wait state adds 1.
- Response: rsp_* are held stable while rsp_valid&&!rsp_ready. rsp_valid clears on the rsp_valid&&rsp_ready edge. The next request can be accepted the cycle after that (no same-cycle reuse).
- After completion, PADDR/PWRITE/PWDATA hold their last values; the next accept overwrites them.
- PSLVERR is sampled only when PSELx&&PENABLE&&PREADY.
- Reset mid-transfer: all outputs go to reset values asynchronously. The in-flight transfer is dropped and produces no response after release.

Decomposition:
- Shared package apb_pkg:
  - apb_state_t enum {IDLE, SETUP, ACCESS}
  - default width constants (APB_ADDR_W=4, APB_DATA_W=128)
  - response struct {rdata, error, timeout}
- One sub-module, apb_wait_timer: clear/enable inputs, expired output, width $clog2(timeout_cycles+1), tied off when timeout_cycles=0.

Test Plan:
1. Zero-wait write:
   - Stimulus: req_write=1, addr=4'h3, wdata=128'hA5A5…A5, PREADY tied 1.
   - Response: one SETUP cycle (PSELx=1, PENABLE=0, PADDR=3), one ACCESS cycle, rsp_valid at accept+3, rsp_error=0, rsp_rdata=0.
2. Read with 2 wait states:
   - Stimulus: addr=4'hC, PREADY=0,0,1, PRDATA=128'h…DEADBEEF.
   - Response: ACCESS lasts 3 cycles with PADDR stable, rsp_valid at accept+5, rsp_rdata=128'h…DEADBEEF.
3. Slave error:
   - Stimulus: PSLVERR=1 together with PREADY=1 on a read.
   - Response: rsp_error=1, rsp_timeout=0. A PSLVERR=1 pulse during SETUP alone gives rsp_error=0.
4. Timeout:
   - Stimulus: timeout_cycles=16, PREADY stuck 0.
   - Response: after 16 ACCESS cycles PSELx/PENABLE drop, rsp_error=1, rsp_timeout=1, rsp_rdata=0.
   - Rerun with PREADY rising on the 16th cycle: normal completion.
5. Backpressure:
   - Stimulus: rsp_ready=0 for 5 cycles while req_valid=1.
   - Response: rsp_* stable, req_ready=0, no new SETUP. After the rsp handshake, the next request is accepted one cycle later.
6. Reset mid-ACCESS:
   - Stimulus: drop PRESETn during wait states.
   - Response: PSELx/PENABLE go to 0 immediately, rsp_valid stays 0 after release, req_ready=1.
   - Integration: write then read-back through the controller + RAM subsystem at addr 4'h5 returns the written data.
